// File: rtl/top.sv
// Serial-to-parallel byte receiver (LSB first) feeding a DEPTH-entry byte FIFO.
// One-cycle latency on every event; status_out low while a byte waits, enqueue into a full queue ignored.
module top #(
   parameter int DEPTH = 8
) (
   input  logic       clock_1MHz,
   input  logic       rst,
   input  logic       data_in,
   input  logic       write_in,
   input  logic       enqueue_in,
   input  logic       dequeue_in,
   output logic       status_out,
   output logic [7:0] data_out
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic {RECV, FULL} state_t;

   state_t        state;
   logic          ready;
   logic          write_prev, enq_prev, deq_prev;
   logic [7:0]    shreg;
   logic [3:0]    bitcnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    mem [DEPTH];

   logic write_ev, enq_ev, deq_ev, do_enq, do_deq;

   assign write_ev = write_in   && !write_prev;
   assign enq_ev   = enqueue_in && !enq_prev;
   assign deq_ev   = dequeue_in && !deq_prev;

   // Both decisions use the pre-cycle count, so a full queue still serves a pop
   // while refusing the push, and an empty queue takes the push but not the pop.
   assign do_enq = enq_ev && (state == FULL) && (count != DEPTH_C);
   assign do_deq = deq_ev && (count != '0);

   // ready holds status_out low for the reset cycle so the sender sees a 0->1 edge.
   assign status_out = ready && (state == RECV);

   always_ff @(posedge clock_1MHz) begin
      if (!rst) begin
         state      <= RECV;
         ready      <= 1'b0;
         write_prev <= 1'b0;
         enq_prev   <= 1'b0;
         deq_prev   <= 1'b0;
         shreg      <= '0;
         bitcnt     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_out   <= '0;
      end else begin
         ready      <= 1'b1;
         write_prev <= write_in;
         enq_prev   <= enqueue_in;
         deq_prev   <= dequeue_in;

         if (write_ev && state == RECV) begin
            shreg  <= {data_in, shreg[7:1]};
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd7)
               state <= FULL;
         end

         if (do_enq) begin
            wr_ptr <= wr_ptr + 1'b1;
            bitcnt <= '0;
            state  <= RECV;
         end

         if (do_deq) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end

         case ({do_enq, do_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock_1MHz) begin
      if (rst && do_enq)
         mem[wr_ptr] <= shreg;
   end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: serial byte assembly, FIFO ordering, full/empty limits, reset.
module tb_top;

   logic       clock_1MHz = 1'b0;
   logic       rst = 1'b0;
   logic       data_in = 1'b0;
   logic       write_in = 1'b0;
   logic       enqueue_in = 1'b0;
   logic       dequeue_in = 1'b0;
   logic       status_out;
   logic [7:0] data_out;

   int n_checks = 0;
   int n_pass   = 0;

   top #(.DEPTH(8)) dut (
      .clock_1MHz (clock_1MHz),
      .rst        (rst),
      .data_in    (data_in),
      .write_in   (write_in),
      .enqueue_in (enqueue_in),
      .dequeue_in (dequeue_in),
      .status_out (status_out),
      .data_out   (data_out)
   );

   always #5 clock_1MHz = ~clock_1MHz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clock_1MHz);
      #1;
   endtask

   task automatic send_bit(input logic b, input int hold);
      data_in  = b;
      write_in = 1'b1;
      tick(hold);
      write_in = 1'b0;
      tick(hold);
   endtask

   task automatic send_bits(input logic [7:0] v, input int lo, input int hi, input int hold);
      for (int i = lo; i <= hi; i++)
         send_bit(v[i], hold);
   endtask

   task automatic pulse_enq(input int len);
      enqueue_in = 1'b1;
      tick(len);
      enqueue_in = 1'b0;
      tick(2);
   endtask

   task automatic pulse_deq(input int len);
      dequeue_in = 1'b1;
      tick(len);
      dequeue_in = 1'b0;
      tick(2);
   endtask

   initial begin
      logic [7:0] v;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_status", status_out, 0);
         check("rst_data", data_out, 8'h00);
      end
      rst = 1'b1;
      tick(1);
      check("post_rst_status", status_out, 1);

      // Single byte with long strobes.
      send_bits(8'h99, 0, 6, 10);
      check("7bits_status", status_out, 1);
      send_bits(8'h99, 7, 7, 10);
      check("8bits_status", status_out, 0);
      pulse_enq(100);
      check("enq_status", status_out, 1);
      pulse_deq(100);
      check("single_byte", data_out, 8'h99);

      // FIFO ordering and empty-queue dequeue.
      for (int k = 1; k <= 3; k++) begin
         v = 8'(k);
         send_bits(v, 0, 7, 2);
         pulse_enq(3);
      end
      for (int k = 1; k <= 3; k++) begin
         pulse_deq(3);
         check("order", data_out, k);
      end
      pulse_deq(3);
      check("empty_deq_hold", data_out, 8'h03);

      // Fill the queue, refuse a ninth byte, then drain across the pointer wrap.
      for (int k = 0; k < 8; k++) begin
         v = 8'h10 + 8'(k);
         send_bits(v, 0, 7, 2);
         pulse_enq(3);
      end
      send_bits(8'h18, 0, 7, 2);
      pulse_enq(3);
      check("full_enq_status", status_out, 0);
      pulse_deq(3);
      check("full_first_deq", data_out, 8'h10);
      check("after_deq_status", status_out, 0);
      pulse_enq(3);
      check("retry_enq_status", status_out, 1);
      for (int k = 1; k <= 8; k++) begin
         pulse_deq(3);
         check("wrap_drain", data_out, 8'h10 + k);
      end

      // Ignored events: write while FULL, enqueue of a partial byte.
      send_bits(8'hA5, 0, 7, 2);
      send_bit(1'b1, 2);
      check("write_in_full_status", status_out, 0);
      pulse_enq(3);
      send_bits(8'h3C, 0, 4, 2);
      pulse_enq(3);
      check("partial_enq_status", status_out, 1);
      send_bits(8'h3C, 5, 7, 2);
      check("completed_status", status_out, 0);
      pulse_enq(3);
      pulse_deq(3);
      check("byte_unchanged", data_out, 8'hA5);
      pulse_deq(3);
      check("partial_kept", data_out, 8'h3C);
      pulse_deq(3);
      check("no_extra_entry", data_out, 8'h3C);

      // Reset with two bytes queued and a half-built byte.
      send_bits(8'h55, 0, 7, 2);
      pulse_enq(3);
      send_bits(8'h66, 0, 7, 2);
      pulse_enq(3);
      send_bits(8'h0F, 0, 3, 2);
      rst = 1'b0;
      tick(1);
      check("mid_rst_status", status_out, 0);
      check("mid_rst_data", data_out, 8'h00);
      rst = 1'b1;
      tick(1);
      check("mid_rst_release", status_out, 1);
      pulse_deq(3);
      check("queue_discarded", data_out, 8'h00);
      send_bits(8'hC3, 0, 6, 2);
      check("fresh_7bits_status", status_out, 1);
      send_bits(8'hC3, 7, 7, 2);
      check("fresh_8bits_status", status_out, 0);
      pulse_enq(3);
      pulse_deq(3);
      check("fresh_byte", data_out, 8'hC3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
